// File: rtl/wb_stage.sv
// Writeback stage: ALU/link/load result selection, load formatting and register-file write.
// Optional WB_RETIRE_CNT_EN adds a 64-bit instret counter output.
module wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_rd_we,
  input  logic [4:0]  in_rd_addr,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        rg_wrt_en,
  output logic [4:0]  rg_wrt_addr,
  output logic [31:0] rg_wrt_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic        ld_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] instret
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE
  } state_t;

  state_t      state;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;
  logic [31:0] data_q;
  logic        en_q;
  logic        err_q;

  logic        accept;
  logic [31:0] sel_data;
  logic [31:0] ld_data;
  logic        ld_ok;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign in_ready = (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sel_data = 32'd0;
    case (in_wb_sel)
      2'b00:   sel_data = in_alu_result;
      2'b10:   sel_data = in_pc_plus4;
      default: sel_data = 32'd0;
    endcase
  end

  assign ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_data = 32'd0;
    ld_ok   = 1'b1;
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = dmem_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rd_q   <= 5'd0;
      we_q   <= 1'b0;
      f3_q   <= 3'd0;
      off_q  <= 2'd0;
      cnt    <= 8'd0;
      data_q <= 32'd0;
      en_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        WAIT_MEM: begin
          if (dmem_rvalid) begin
            if (ld_ok) begin
              data_q <= ld_data;
              en_q   <= we_q && (rd_q != 5'd0);
              state  <= WRITE;
            end else begin
              err_q <= 1'b1;
              state <= IDLE;
            end
          end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          if (accept) begin
            rd_q <= in_rd_addr;
            we_q <= in_rd_we;
            if (in_wb_sel == 2'b01) begin
              f3_q  <= in_funct3;
              off_q <= in_alu_result[1:0];
              cnt   <= 8'd0;
              state <= WAIT_MEM;
            end else begin
              data_q <= sel_data;
              en_q   <= in_rd_we && (in_rd_addr != 5'd0)
                        && (in_wb_sel != 2'b11);
              state  <= WRITE;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign rg_wrt_en   = en_q;
  assign rg_wrt_addr = rd_q;
  assign rg_wrt_data = data_q;
  assign fwd_valid   = en_q;
  assign fwd_addr    = rd_q;
  assign fwd_data    = data_q;
  assign ld_err      = err_q;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= 64'd0;
    end else if (state == WRITE) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, default 64, max cycles waiting in WAIT_MEM before abort (1..255).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_rd_we  in  1  instruction writes rd.
- in_rd_addr  in  5  destination register.
- in_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 none.
- in_alu_result  in  32  ALU result; for loads, byte address.
- in_pc_plus4  in  32  link value.
- in_funct3  in  3  load size/sign.
- dmem_rdata  in  32  memory word.
- dmem_rvalid  in  1  memory data valid.
- rg_wrt_en  out  1  register-file write enable.
- rg_wrt_addr  out  5  register-file write address.
- rg_wrt_data  out  32  register-file write data.
- fwd_valid  out  1  forwarding entry valid.
- fwd_addr  out  5  forwarding address.
- fwd_data  out  32  forwarding data.
- ld_err  out  1  one-cycle error pulse.

Function
REQ-003 SHALL implement FSM IDLE, WAIT_MEM, WRITE; in_ready=1 in IDLE and WRITE, 0 in WAIT_MEM.
REQ-004 SHALL accept on in_valid&&in_ready: wb_sel 01 -> WAIT_MEM latching rd/we/funct3/addr[1:0]; else -> WRITE with data latched (ALU, PC+4, or 0 for 11).
REQ-005 SHALL in WRITE assert rg_wrt_en for exactly that cycle iff latched we=1, rd!=0 and wb_sel!=11; then IDLE, or re-branch per REQ-004 if accepting same cycle.
REQ-006 SHALL drive rg_wrt_addr/rg_wrt_data from registers only; latency accept->write 1 cycle (non-load), dmem_rvalid->write 1 cycle (load).
REQ-007 SHALL format loads on dmem_rvalid: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane addr[1:0], halfword lane addr[1], word ignores offset.
REQ-008 SHALL treat funct3 011/110/111 as reserved: pulse ld_err, no write, go IDLE on that rvalid.
REQ-009 SHALL ignore dmem_rvalid outside WAIT_MEM.
REQ-010 SHALL count WAIT_MEM cycles; when count reaches MEM_TIMEOUT without rvalid, pulse ld_err, no write, return IDLE.
REQ-011 SHALL drive fwd_valid=1, fwd_addr=rd, fwd_data=write data in WRITE when rg_wrt_en=1; else fwd_valid=0.
REQ-012 SHALL never write register 0.

Reset
REQ-013 SHALL on reset go to IDLE; rg_wrt_en, fwd_valid, ld_err, timeout counter, latched fields = 0; in_ready=1 the cycle after reset deasserts.
REQ-014 SHALL discard any pending load or write when reset asserts mid-operation; no write occurs on that or following cycle.

Configuration
REQ-015 SHALL, with WB_RETIRE_CNT_EN defined, add output instret (64 bits), reset to 0, incremented once per completed WRITE-state cycle (writing or not), excluding errors; without it, port and counter absent.

Verification
REQ-016 ALU op rd=5, result 0x1234 accepted cycle N -> rg_wrt_en=1, addr 5, data 0x00001234 at N+1.
REQ-017 LB addr 0x...3, dmem_rdata 0x80FF_FF7F after 3-cycle wait -> data 0xFFFFFF80 one cycle after rvalid; LBU same -> 0x00000080.
REQ-018 ALU op with rd=0, we=1 -> rg_wrt_en stays 0, fwd_valid 0.
REQ-019 Load, no rvalid for MEM_TIMEOUT=4 cycles -> ld_err pulse, no write, in_ready returns 1.
REQ-020 Reset asserted during WAIT_MEM, then rvalid -> no write, state IDLE, all outputs 0.
REQ-021 Back-to-back ALU ops every cycle -> one write per cycle, in_ready held 1.
